// File: rtl/shot_scorer.sv
// Game-round controller: arms shots, launches the trajectory calculator and
// keeps score, remaining shots and a pseudo-random target.
module shot_scorer #(
    parameter int         SHOTS     = 8,
    parameter int         SCORE_W   = 8,
    parameter int         TIMEOUT   = 63,
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               fire,
    input  logic               result_valid,
    input  logic               hit,
    output logic               shoot,
    output logic [4:0]         target_x,
    output logic [4:0]         target_y,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         shots_left,
    output logic               game_over,
    output logic               busy
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FLIGHT,
        S_OVER
    } state_e;

    state_e             state_q, state_d;
    logic               shoot_q, shoot_d;
    logic [4:0]         tx_q, tx_d;
    logic [4:0]         ty_q, ty_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         shots_q, shots_d;
    logic [9:0]         lfsr_q, lfsr_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [4:0]         new_tx;
    logic [4:0]         new_ty;
    logic               resolve;

    // Target row 0 is not allowed, so an all-zero upper field maps to row 1.
    assign new_tx = lfsr_q[4:0];
    assign new_ty = (lfsr_q[9:5] == 5'd0) ? 5'd1 : lfsr_q[9:5];

    assign resolve = result_valid || (timer_q == TW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        shoot_d = 1'b0;
        tx_d    = tx_q;
        ty_d    = ty_q;
        score_d = score_q;
        shots_d = shots_q;
        timer_d = timer_q;
        lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d = S_ARMED;
                    shots_d = 4'(SHOTS);
                    score_d = '0;
                    tx_d    = new_tx;
                    ty_d    = new_ty;
                end
            end
            S_ARMED: begin
                if (start) begin
                    shots_d = 4'(SHOTS);
                    score_d = '0;
                    tx_d    = new_tx;
                    ty_d    = new_ty;
                end else if (fire) begin
                    state_d = S_FLIGHT;
                    shoot_d = 1'b1;
                    timer_d = '0;
                end
            end
            S_FLIGHT: begin
                if (resolve) begin
                    shots_d = shots_q - 4'd1;
                    state_d = (shots_q == 4'd1) ? S_OVER : S_ARMED;
                    // A timeout only resolves as a hit when result_valid came with it.
                    if (result_valid && hit) begin
                        tx_d = new_tx;
                        ty_d = new_ty;
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shoot_q <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            score_q <= '0;
            shots_q <= '0;
            lfsr_q  <= LFSR_SEED;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            shoot_q <= shoot_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            score_q <= score_d;
            shots_q <= shots_d;
            lfsr_q  <= lfsr_d;
            timer_q <= timer_d;
        end
    end

    assign shoot      = shoot_q;
    assign target_x   = tx_q;
    assign target_y   = ty_q;
    assign score      = score_q;
    assign shots_left = shots_q;
    assign game_over  = (state_q == S_OVER);
    assign busy       = (state_q == S_FLIGHT);

endmodule

// File: tb/tb_shot_scorer.sv
// Scoreboard bench for shot_scorer: expected output snapshots are queued
// when stimulus is driven and compared after the DUT responds.
module tb_shot_scorer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       fire;
    logic       result_valid;
    logic       hit;
    logic       shoot;
    logic [4:0] target_x;
    logic [4:0] target_y;
    logic [7:0] score;
    logic [3:0] shots_left;
    logic       game_over;
    logic       busy;

    logic       shoot2;
    logic [4:0] target_x2;
    logic [4:0] target_y2;
    logic [1:0] score2;
    logic [3:0] shots_left2;
    logic       game_over2;
    logic       busy2;

    typedef struct packed {
        logic       go;
        logic       bsy;
        logic [3:0] shots;
        logic [7:0] scr;
        logic [4:0] tx;
        logic [4:0] ty;
    } snap_t;

    snap_t      sb[$];
    int         total;
    int         bad;

    logic [9:0] m_lfsr;
    logic [7:0] exp_score;
    logic [3:0] exp_shots;
    logic [4:0] exp_tx;
    logic [4:0] exp_ty;

    shot_scorer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fire(fire),
        .result_valid(result_valid), .hit(hit), .shoot(shoot),
        .target_x(target_x), .target_y(target_y), .score(score),
        .shots_left(shots_left), .game_over(game_over), .busy(busy)
    );

    shot_scorer #(.SCORE_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .fire(fire),
        .result_valid(result_valid), .hit(hit), .shoot(shoot2),
        .target_x(target_x2), .target_y(target_y2), .score(score2),
        .shots_left(shots_left2), .game_over(game_over2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, x^10 + x^7 + 1, shifting every cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 10'h2A5;
        else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic snap_t cur();
        return {game_over, busy, shots_left, score, target_x, target_y};
    endfunction

    function automatic snap_t mk(input logic go, input logic bsy);
        return {go, bsy, exp_shots, exp_score, exp_tx, exp_ty};
    endfunction

    task automatic new_target();
        exp_tx = m_lfsr[4:0];
        exp_ty = (m_lfsr[9:5] == 5'd0) ? 5'd1 : m_lfsr[9:5];
    endtask

    task automatic clear_exp();
        exp_score = '0;
        exp_shots = '0;
        exp_tx    = '0;
        exp_ty    = '0;
    endtask

    task automatic do_start(input string nm);
        snap_t e;
        start = 1'b1;
        exp_score = '0;
        exp_shots = 4'd8;
        new_target();
        sb.push_back(mk(1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        e = sb.pop_front();
        total++;
        if (cur() !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, cur(), e);
        end
        total++;
        if (target_y === 5'd0) begin
            bad++;
            $display("FAIL %s_ty_nonzero: got %0d want nonzero", nm, target_y);
        end
    endtask

    task automatic fire_shot(input string nm);
        fire = 1'b1;
        @(negedge clk);
        total++;
        if (shoot !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_launch: shoot=%b busy=%b want 1 1", nm, shoot, busy);
        end
        fire = 1'b0;
        @(negedge clk);
        total++;
        if (shoot !== 1'b0) begin
            bad++;
            $display("FAIL %s_pulse_len: shoot=%b want 0", nm, shoot);
        end
    endtask

    task automatic resolve(input logic h, input string nm);
        snap_t e;
        result_valid = 1'b1;
        hit = h;
        exp_shots = exp_shots - 4'd1;
        if (h) begin
            if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
            new_target();
        end
        sb.push_back(mk(exp_shots == 4'd0, 1'b0));
        @(negedge clk);
        result_valid = 1'b0;
        hit = 1'b0;
        e = sb.pop_front();
        total++;
        if (cur() !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, cur(), e);
        end
    endtask

    task automatic test_reset();
        snap_t e;
        rst_n = 1'b0;
        clear_exp();
        sb.push_back(mk(1'b0, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (cur() !== e || shoot !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: got %h shoot=%b want %h 0", cur(), shoot, e);
        end
        rst_n = 1'b1;
        @(negedge clk);
        do_start("first_start");
    endtask

    task automatic test_hit();
        fire_shot("hit_shot");
        resolve(1'b1, "hit_resolve");
    endtask

    task automatic test_timeout();
        snap_t e;
        int n;
        fire_shot("to_shot");
        exp_shots = exp_shots - 4'd1;
        sb.push_back(mk(1'b0, 1'b0));
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != 63) begin
            bad++;
            $display("FAIL timeout_len: got %0d cycles want 63", n);
        end
        e = sb.pop_front();
        total++;
        if (cur() !== e) begin
            bad++;
            $display("FAIL timeout_miss: got %h want %h", cur(), e);
        end
        fire_shot("edge_shot");
        repeat (62) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL edge_busy: got %b want 1", busy);
        end
        resolve(1'b1, "edge_hit");
    endtask

    task automatic test_game_over();
        snap_t e;
        int k;
        k = 0;
        while (exp_shots != 4'd0 && k < 20) begin
            fire_shot("go_shot");
            resolve(k[0], "go_resolve");
            k++;
        end
        total++;
        if (game_over !== 1'b1 || shots_left !== 4'd0) begin
            bad++;
            $display("FAIL game_over: go=%b shots=%0d want 1 0", game_over, shots_left);
        end
        fire = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1'b1, 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (cur() !== e || shoot !== 1'b0) begin
                bad++;
                $display("FAIL over_fire: got %h shoot=%b want %h 0", cur(), shoot, e);
            end
        end
        fire = 1'b0;
        do_start("restart");
    endtask

    task automatic test_saturation();
        snap_t e;
        for (int i = 0; i < 4; i++) begin
            fire_shot("sat_shot");
            resolve(1'b1, "sat_hit");
        end
        total++;
        if (score2 !== 2'd3) begin
            bad++;
            $display("FAIL sat_score: got %0d want 3", score2);
        end
        result_valid = 1'b1;
        hit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(1'b0, 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (cur() !== e || score2 !== 2'd3) begin
                bad++;
                $display("FAIL armed_rv: got %h s2=%0d want %h 3", cur(), score2, e);
            end
        end
        result_valid = 1'b0;
        hit = 1'b0;
    endtask

    task automatic test_reset_flight();
        snap_t e;
        fire_shot("rst_shot");
        #2;
        rst_n = 1'b0;
        clear_exp();
        sb.push_back(mk(1'b0, 1'b0));
        #1;
        e = sb.pop_front();
        total++;
        if (cur() !== e || shoot !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got %h shoot=%b want %h 0", cur(), shoot, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        result_valid = 1'b1;
        hit = 1'b1;
        sb.push_back(mk(1'b0, 1'b0));
        @(negedge clk);
        result_valid = 1'b0;
        hit = 1'b0;
        e = sb.pop_front();
        total++;
        if (cur() !== e) begin
            bad++;
            $display("FAIL post_rst_rv: got %h want %h", cur(), e);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        fire = 1'b0;
        result_valid = 1'b0;
        hit = 1'b0;
        clear_exp();
        test_reset();
        test_hit();
        test_timeout();
        test_game_over();
        test_saturation();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
